// File: rtl/s_axis_kernel_collector_pkg.sv
// Shared remapper definitions: kernel geometry defaults, kernel array type, collector states.
package remapper_pkg;

  localparam int unsigned DATA_WIDTH_DEF       = 8;
  localparam int unsigned IMAGE_KERNEL_12K_DEF = 64;

  typedef logic [0:IMAGE_KERNEL_12K_DEF-1][DATA_WIDTH_DEF-1:0] kernel_t;

  // Collector FSM encoding
  localparam logic [1:0] StWaitSof = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StFull    = 2'd2;

endpackage

// File: rtl/s_axis_kernel_collector_if.sv
// AXI4-Stream video beat bundle: tuser marks start of frame, tlast marks end of line.
interface s_axis_kernel_collector_if
  import remapper_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tuser;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);

endinterface

// File: rtl/s_axis_kernel_collector_kernel_pingpong_buf.sv
// Two kernel register banks: one being filled, one presented; occupancy tracks unconsumed kernels.
module kernel_pingpong_buf
  import remapper_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int unsigned IMAGE_KERNEL_12K = IMAGE_KERNEL_12K_DEF,
  localparam int unsigned KaddrW          = $clog2(IMAGE_KERNEL_12K)
) (
  input  logic                                        i_clk,
  input  logic                                        i_aresetn,
  input  logic                                        i_wr_en,
  input  logic [KaddrW-1:0]                           i_wr_addr,
  input  logic [DATA_WIDTH-1:0]                       i_wr_data,
  input  logic                                        i_wr_sof,
  input  logic                                        i_wr_last,
  input  logic                                        i_ack,
  output logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0] o_kernel,
  output logic                                        o_valid,
  output logic                                        o_sof,
  output logic                                        o_fill_free_d
);

  logic [1:0][0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0] r_bank;
  logic [1:0] r_occ, w_occ_d, r_sof;
  logic       r_fill_sel, r_pres_sel, w_fill_sel_d, w_pres_sel_d, w_take, w_done;

  assign w_take       = r_occ[r_pres_sel] & i_ack;
  assign w_done       = i_wr_en & i_wr_last;
  assign w_fill_sel_d = r_fill_sel ^ w_done;
  assign w_pres_sel_d = r_pres_sel ^ w_take;

  // Next occupancy: ack frees the presented bank, completion claims the fill bank
  always_comb begin
    w_occ_d = r_occ;
    if (w_take) w_occ_d[r_pres_sel] = 1'b0;
    if (w_done) w_occ_d[r_fill_sel] = 1'b1;
  end

  // Upstream may write next cycle only if the bank it will fill is free
  assign o_fill_free_d = ~w_occ_d[w_fill_sel_d];

  assign o_kernel = r_bank[r_pres_sel];
  assign o_valid  = r_occ[r_pres_sel];
  assign o_sof    = r_sof[r_pres_sel] & r_occ[r_pres_sel];

  // Bank writes, select pointers and occupancy
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_bank     <= '0;
      r_sof      <= '0;
      r_occ      <= '0;
      r_fill_sel <= 1'b0;
      r_pres_sel <= 1'b0;
    end else begin
      if (i_wr_en) r_bank[r_fill_sel][i_wr_addr] <= i_wr_data;
      if (i_wr_en && (i_wr_addr == '0)) r_sof[r_fill_sel] <= i_wr_sof;
      r_occ      <= w_occ_d;
      r_fill_sel <= w_fill_sel_d;
      r_pres_sel <= w_pres_sel_d;
    end
  end

endmodule

// File: rtl/s_axis_kernel_collector.sv
// Receive side of the remapper pixel stream: packs pixels into kernels and checks line/frame framing.
module s_axis_kernel_collector
  import remapper_pkg::*;
#(
  parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
  parameter int unsigned IMAGE_KERNEL_12K = IMAGE_KERNEL_12K_DEF
) (
  input  logic                                        i_clk,
  input  logic                                        i_aresetn,
  input  logic [12:0]                                 WIDTH,
  input  logic [12:0]                                 HEIGHT,
  s_axis_kernel_collector_if.slave                    s_axis,
  output logic [0:IMAGE_KERNEL_12K-1][DATA_WIDTH-1:0] o_image_kernel,
  output logic                                        o_kernel_valid,
  output logic                                        o_kernel_sof,
  input  logic                                        i_kernel_ack,
  output logic                                        o_line_err,
  output logic                                        o_frame_err
);

  localparam int unsigned       KaddrW    = $clog2(IMAGE_KERNEL_12K);
  localparam logic [KaddrW-1:0] KaddrLast = KaddrW'(IMAGE_KERNEL_12K - 1);

  logic [1:0]        r_state, w_state_d, r_resume, w_resume;
  logic [KaddrW-1:0] r_kaddr, w_kaddr_d, w_kaddr_eff;
  logic [11:0]       r_pix, w_pix_d, w_pix_eff, r_line, w_line_d, w_line_eff;
  logic r_tready, r_eof_pend, w_eof_pend_d, r_after_frame, w_after_frame_d;
  logic r_line_err, w_line_err, r_frame_err, w_frame_err;
  logic w_accept, w_beat, w_restart, w_last_pix, w_last_line, w_complete, w_done, w_fill_free_d;

  assign w_accept      = s_axis.tvalid & r_tready;
  assign s_axis.tready = r_tready;
  assign o_line_err    = r_line_err;
  assign o_frame_err   = r_frame_err;

  // A new frame always lands at slot 0, pixel 0, line 0
  assign w_kaddr_eff = w_restart ? '0 : r_kaddr;
  assign w_pix_eff   = w_restart ? '0 : r_pix;
  assign w_line_eff  = w_restart ? '0 : r_line;
  assign w_last_pix  = ({1'b0, w_pix_eff} == (WIDTH - 13'd1));
  assign w_last_line = ({1'b0, w_line_eff} == (HEIGHT - 13'd1));
  assign w_complete  = w_beat & (w_kaddr_eff == KaddrLast);

  // Classify the accepted beat: store, drop, or restart a frame
  always_comb begin
    w_beat      = 1'b0;
    w_restart   = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      StWaitSof: begin
        if (w_accept) begin
          if (s_axis.tuser) begin
            w_beat    = 1'b1;
            w_restart = 1'b1;
          end else begin
            w_frame_err = r_after_frame;
          end
        end
      end
      StCollect: begin
        if (w_accept) begin
          w_beat = 1'b1;
          if (s_axis.tuser) begin
            // Any tuser discards the partial kernel; only mid-frame ones are errors
            w_restart   = 1'b1;
            w_frame_err = (r_pix != '0) || (r_line != '0);
          end else begin
            w_frame_err = r_eof_pend && (r_pix == '0) && (r_line == '0);
          end
        end
      end
      default: ;
    endcase
  end

  // Kernel address, pixel/line counters and framing checks
  always_comb begin
    w_kaddr_d       = r_kaddr;
    w_pix_d         = r_pix;
    w_line_d        = r_line;
    w_line_err      = 1'b0;
    w_eof_pend_d    = r_eof_pend;
    w_after_frame_d = r_after_frame;
    w_done          = 1'b0;
    if (w_restart || w_frame_err) w_after_frame_d = 1'b0;
    if (w_beat) begin
      w_kaddr_d = w_kaddr_eff + KaddrW'(1);
      if (w_restart) w_eof_pend_d = 1'b0;
      if (s_axis.tlast || w_last_pix) begin
        w_line_err = s_axis.tlast ^ w_last_pix;
        w_pix_d    = '0;
        w_line_d   = w_last_line ? '0 : w_line_eff + 12'd1;
      end else begin
        w_pix_d = w_pix_eff + 12'd1;
      end
      if (w_last_pix && w_last_line) w_eof_pend_d = 1'b1;
      // Frame is over once the kernel holding its last pixel completes
      if (w_complete && w_eof_pend_d) begin
        w_done          = 1'b1;
        w_eof_pend_d    = 1'b0;
        w_after_frame_d = 1'b1;
      end
    end
  end

  // FSM: FULL remembers whether to resume collecting or wait for the next frame
  always_comb begin
    w_resume  = r_resume;
    w_state_d = r_state;
    case (r_state)
      StWaitSof, StCollect: begin
        if (w_done)      w_resume = StWaitSof;
        else if (w_beat) w_resume = StCollect;
        else             w_resume = r_state;
        w_state_d = w_fill_free_d ? w_resume : StFull;
      end
      StFull: begin
        if (w_fill_free_d) w_state_d = r_resume;
      end
      default: w_state_d = StWaitSof;
    endcase
  end

  // State registers; tready is precomputed from next-cycle occupancy so no beat is lost
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state       <= StWaitSof;
      r_resume      <= StWaitSof;
      r_kaddr       <= '0;
      r_pix         <= '0;
      r_line        <= '0;
      r_tready      <= 1'b0;
      r_eof_pend    <= 1'b0;
      r_after_frame <= 1'b0;
      r_line_err    <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_resume      <= w_resume;
      r_kaddr       <= w_kaddr_d;
      r_pix         <= w_pix_d;
      r_line        <= w_line_d;
      r_tready      <= w_fill_free_d;
      r_eof_pend    <= w_eof_pend_d;
      r_after_frame <= w_after_frame_d;
      r_line_err    <= w_line_err;
      r_frame_err   <= w_frame_err;
    end
  end

  kernel_pingpong_buf #(
    .DATA_WIDTH      (DATA_WIDTH),
    .IMAGE_KERNEL_12K(IMAGE_KERNEL_12K)
  ) u_buf (
    .i_clk        (i_clk),
    .i_aresetn    (i_aresetn),
    .i_wr_en      (w_beat),
    .i_wr_addr    (w_kaddr_eff),
    .i_wr_data    (s_axis.tdata),
    .i_wr_sof     (s_axis.tuser),
    .i_wr_last    (w_complete),
    .i_ack        (i_kernel_ack),
    .o_kernel     (o_image_kernel),
    .o_valid      (o_kernel_valid),
    .o_sof        (o_kernel_sof),
    .o_fill_free_d(w_fill_free_d)
  );

endmodule

// File: tb/tb_s_axis_kernel_collector.sv
// Directed bench for the kernel collector: packing, back-pressure, framing errors, reset.
module tb_s_axis_kernel_collector;
  import remapper_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] width = 13'd128;
  logic [12:0] height = 13'd2;
  kernel_t     kernel;
  logic        kvalid, ksof, line_err, frame_err;
  logic        ack = 1'b0;

  always #5 clk = ~clk;

  s_axis_kernel_collector_if #(.DATA_WIDTH(8)) axis ();

  s_axis_kernel_collector #(
    .DATA_WIDTH      (8),
    .IMAGE_KERNEL_12K(64)
  ) dut (
    .i_clk         (clk),
    .i_aresetn     (rst_n),
    .WIDTH         (width),
    .HEIGHT        (height),
    .s_axis        (axis),
    .o_image_kernel(kernel),
    .o_kernel_valid(kvalid),
    .o_kernel_sof  (ksof),
    .i_kernel_ack  (ack),
    .o_line_err    (line_err),
    .o_frame_err   (frame_err)
  );

  int      n_cmp = 0;
  int      n_bad = 0;
  int      acc_cnt = 0;
  int      stall_cnt = 0;
  int      n_line = 0;
  int      n_frame = 0;
  logic    prev_stall = 1'b0;
  int      onset_q[$];
  kernel_t kq[$];
  bit      sq[$];
  int      b_acc, b_stall, b_line, b_frame, b_kq, b_onset;

  // Observe the stream and consumer side away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (axis.tvalid && axis.tready) acc_cnt <= acc_cnt + 1;
      if (axis.tvalid && !axis.tready) begin
        stall_cnt <= stall_cnt + 1;
        if (!prev_stall) onset_q.push_back(acc_cnt);
      end
      prev_stall <= axis.tvalid && !axis.tready;
      if (kvalid && ack) begin
        kq.push_back(kernel);
        sq.push_back(ksof);
      end
      if (line_err)  n_line  <= n_line + 1;
      if (frame_err) n_frame <= n_frame + 1;
    end
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mark();
    b_acc   = acc_cnt;
    b_stall = stall_cnt;
    b_line  = n_line;
    b_frame = n_frame;
    b_kq    = kq.size();
    b_onset = onset_q.size();
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is accepted
  task automatic push(input logic [7:0] d, input logic u, input logic l);
    int waited = 0;
    axis.tdata  = d;
    axis.tuser  = u;
    axis.tlast  = l;
    axis.tvalid = 1'b1;
    @(negedge clk);
    while (!axis.tready && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (!axis.tready) begin
      check_eq("push_ready_timeout", axis.tready, 1);
      axis.tvalid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    axis.tvalid = 1'b0;
    axis.tuser  = 1'b0;
    axis.tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Kernel n of a frame holds pixel indices 64n..64n+63, value = index & 0xFF
  task automatic check_kernels(input string tag, input int exp_n);
    int got_n = kq.size() - b_kq;
    check_eq($sformatf("%s kernel_count", tag), got_n, exp_n);
    for (int n = 0; n < exp_n && n < got_n; n++) begin
      int bad = 0;
      for (int i = 0; i < 64; i++) begin
        logic [7:0] e = 8'(64 * n + i);
        if (kq[b_kq+n][i] !== e) bad++;
      end
      check_eq($sformatf("%s k%0d bad_slots", tag, n), bad, 0);
      check_eq($sformatf("%s k%0d sof", tag, n), sq[b_kq+n], (n == 0) ? 1 : 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    axis.tdata  = '0;
    axis.tvalid = 1'b0;
    axis.tuser  = 1'b0;
    axis.tlast  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst tready", axis.tready, 0);
    check_eq("rst kvalid", kvalid, 0);
    check_eq("rst ksof", ksof, 0);
    check_eq("rst kernel_or", |kernel, 0);
    check_eq("rst line_err", line_err, 0);
    check_eq("rst frame_err", frame_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("tready after reset", axis.tready, 1);

    // Continuous frame, ack always high
    ack = 1'b1;
    mark();
    for (int p = 0; p < 256; p++) begin
      push(8'(p), p == 0, (p % 128) == 127);
      if (p == 62) check_eq("t1 valid_before_k0", kvalid, 0);
      if (p == 63) check_eq("t1 valid_latency", kvalid, 1);
    end
    idle(10);
    check_kernels("t1", 4);
    check_eq("t1 stalls", stall_cnt - b_stall, 0);
    check_eq("t1 line_err", n_line - b_line, 0);
    check_eq("t1 frame_err", n_frame - b_frame, 0);

    // Consumer stalls for 200 cycles
    ack = 1'b0;
    mark();
    fork
      begin
        for (int p = 0; p < 256; p++) push(8'(p), p == 0, (p % 128) == 127);
      end
      begin
        repeat (200) @(posedge clk);
        #1;
        ack = 1'b1;
      end
    join
    idle(10);
    check_eq("t2 stall_seen", (stall_cnt - b_stall) > 0, 1);
    if (onset_q.size() > b_onset) check_eq("t2 stall_after_beats", onset_q[b_onset] - b_acc, 128);
    else check_eq("t2 stall_onset_count", onset_q.size() - b_onset, 1);
    check_kernels("t2", 4);

    // Kernel 1 completes on the same edge that kernel 0 is acked
    ack = 1'b0;
    mark();
    for (int p = 0; p < 127; p++) push(8'(p), p == 0, 1'b0);
    ack = 1'b1;
    for (int p = 127; p < 256; p++) push(8'(p), 1'b0, (p % 128) == 127);
    idle(10);
    check_eq("t3 stalls", stall_cnt - b_stall, 0);
    check_eq("t3 accepted", acc_cnt - b_acc, 256);
    check_kernels("t3", 4);

    // Early tlast at pixel 100 of line 0
    mark();
    for (int p = 0; p < 229; p++) push(8'(p), p == 0, (p == 100) || (p == 228));
    idle(10);
    check_eq("t4 line_err", n_line - b_line, 1);
    check_eq("t4 frame_err", n_frame - b_frame, 0);
    check_kernels("t4", 3);

    // tuser at pixel 30 of line 0 restarts the frame
    mark();
    for (int p = 0; p < 30; p++) push(8'h55, p == 0, 1'b0);
    for (int p = 0; p < 256; p++) push(8'(p), p == 0, (p % 128) == 127);
    idle(10);
    check_eq("t5 frame_err", n_frame - b_frame, 1);
    check_eq("t5 line_err", n_line - b_line, 0);
    check_kernels("t5", 4);

    // Reset mid-kernel, then beats without tuser are dropped
    mark();
    for (int p = 0; p < 20; p++) push(8'h11, p == 0, 1'b0);
    axis.tvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("t6 rst tready", axis.tready, 0);
    check_eq("t6 rst kvalid", kvalid, 0);
    check_eq("t6 rst ksof", ksof, 0);
    check_eq("t6 rst kernel_or", |kernel, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int p = 0; p < 10; p++) push(8'h22, 1'b0, 1'b0);
    idle(5);
    check_eq("t6 dropped kvalid", kvalid, 0);
    check_eq("t6 dropped kernel_or", |kernel, 0);
    check_eq("t6 dropped frame_err", n_frame - b_frame, 0);
    check_eq("t6 dropped kernels", kq.size() - b_kq, 0);
    for (int p = 0; p < 64; p++) push(8'(p), p == 0, 1'b0);
    idle(5);
    check_kernels("t6", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
